// File: rtl/idct_prod_accum.sv
// IDCT product accumulator: sums N_TERMS signed products, rounds, shifts and
// saturates the result, and hands each coefficient downstream with valid/ready.
module idct_prod_accum #(
    parameter int N_TERMS   = 8,
    parameter int P_WIDTH   = 32,
    parameter int ACC_WIDTH = 35,
    parameter int SHIFT     = 8,
    parameter int OUT_WIDTH = 16,
    parameter int BLK_SIZE  = 64
) (
    input  logic                        clk,
    input  logic                        rstP,
    input  logic [P_WIDTH-1:0]          P_in,
    input  logic                        p_valid,
    output logic                        p_ready,
    output logic [OUT_WIDTH-1:0]        out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(BLK_SIZE)-1:0] out_idx,
    output logic                        out_sat,
    output logic                        out_last
);

    // state | meaning
    // ACC   | accepting products into the accumulator
    // FLUSH | round/shift/saturate the sum into the output registers
    // HOLD  | coefficient presented, waiting for out_ready
    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_FLUSH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(N_TERMS);
    localparam int IDX_W = $clog2(BLK_SIZE);

    localparam logic signed [ACC_WIDTH:0] ROUND_K = (ACC_WIDTH+1)'(1) << (SHIFT-1);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((2**(OUT_WIDTH-1))-1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]            r_term_cnt;
    logic [IDX_W-1:0]            r_idx;
    logic [OUT_WIDTH-1:0]        r_out_data;
    logic                        r_out_sat;
    logic                        r_out_last;
    logic [IDX_W-1:0]            r_out_idx;

    logic                        w_accept;
    logic                        w_last_term;
    logic signed [ACC_WIDTH-1:0] w_p_ext;
    logic signed [ACC_WIDTH:0]   w_rounded;
    logic signed [ACC_WIDTH:0]   w_shifted;
    logic                        w_sat_hi;
    logic                        w_sat_lo;
    logic [OUT_WIDTH-1:0]        w_out_data_nxt;

    assign w_accept    = p_valid && (r_state == S_ACC);
    assign w_last_term = (r_term_cnt == CNT_W'(N_TERMS-1));
    assign w_p_ext     = {{(ACC_WIDTH-P_WIDTH){P_in[P_WIDTH-1]}}, P_in};

    // One extra bit of headroom so the rounding constant can never wrap the sum.
    assign w_rounded = $signed({r_acc[ACC_WIDTH-1], r_acc}) + ROUND_K;
    assign w_shifted = w_rounded >>> SHIFT;
    assign w_sat_hi  = (w_shifted > SAT_MAX);
    assign w_sat_lo  = (w_shifted < SAT_MIN);

    always_comb begin
        w_out_data_nxt = w_shifted[OUT_WIDTH-1:0];
        if (w_sat_hi) begin
            w_out_data_nxt = SAT_MAX[OUT_WIDTH-1:0];
        end else if (w_sat_lo) begin
            w_out_data_nxt = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rstP) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ACC:   if (w_accept && w_last_term) w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = S_HOLD;
            S_HOLD:  if (out_ready) w_state_nxt = S_ACC;
            default: w_state_nxt = S_ACC;
        endcase
    end

    // Handshake flags depend on state only, so nothing combinational leaks from the inputs.
    always_comb begin
        p_ready   = (r_state == S_ACC);
        out_valid = (r_state == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rstP) begin
            r_acc      <= '0;
            r_term_cnt <= '0;
            r_idx      <= '0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
            r_out_last <= 1'b0;
            r_out_idx  <= '0;
        end else begin
            case (r_state)
                S_ACC: begin
                    if (w_accept) begin
                        r_acc      <= r_acc + w_p_ext;
                        r_term_cnt <= w_last_term ? '0 : r_term_cnt + 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_out_data <= w_out_data_nxt;
                    r_out_sat  <= w_sat_hi || w_sat_lo;
                    r_out_idx  <= r_idx;
                    r_out_last <= (r_idx == IDX_W'(BLK_SIZE-1));
                    r_acc      <= '0;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_idx <= (r_idx == IDX_W'(BLK_SIZE-1)) ? '0 : r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = r_out_data;
    assign out_sat  = r_out_sat;
    assign out_last = r_out_last;
    assign out_idx  = r_out_idx;

endmodule

// File: tb/tb_idct_prod_accum.sv
// Directed bench for idct_prod_accum: table of 8-product coefficients with
// hand-computed results, plus backpressure, index-wrap and reset sequences.
module tb_idct_prod_accum;

    logic        clk = 1'b0;
    logic        rstP;
    logic [31:0] P_in;
    logic        p_valid;
    logic        p_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_idx;
    logic        out_sat;
    logic        out_last;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_idx = 0;

    idct_prod_accum dut (
        .clk       (clk),
        .rstP      (rstP),
        .P_in      (P_in),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_sat   (out_sat),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Coefficient = first product followed by seven copies of rest.
    typedef struct packed {
        logic [31:0] first;
        logic [31:0] rest;
        logic [15:0] exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstP = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rstP = 1'b0;
        exp_idx = 0;
    endtask

    // Drive one product and wait (bounded) for it to be accepted.
    task automatic send(input logic [31:0] p);
        int n = 0;
        while (!p_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!p_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: p_ready stuck at 0 expected 1");
        end
        P_in    = p;
        p_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        p_valid = 1'b0;
    endtask

    task automatic send_terms(input logic [31:0] first, input logic [31:0] rest);
        send(first);
        for (int k = 1; k < 8; k++) send(rest);
    endtask

    task automatic check_out(input logic [15:0] ed, input logic es);
        chk("data", 32'(out_data), 32'(ed));
        chk("sat", 32'(out_sat), 32'(es));
        chk("idx", 32'(out_idx), 32'(exp_idx));
        chk("last", 32'(out_last), 32'(exp_idx == 63));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        exp_idx = (exp_idx + 1) % 64;
    endtask

    // Full coefficient: 8 products, latency check, result check, handshake.
    task automatic run_coef(input logic [31:0] first, input logic [31:0] rest,
                            input logic [15:0] ed, input logic es);
        send_terms(first, rest);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(p_ready), 32'd0);
        @(negedge clk);
        chk("hold_valid", 32'(out_valid), 32'd1);
        check_out(ed, es);
        handshake();
    endtask

    initial begin
        logic [15:0] held_data;
        logic [5:0]  held_idx;

        vecs[0]  = '{32'd256,        32'd256,        16'd8,      1'b0};
        vecs[1]  = '{32'd384,        32'd0,          16'd2,      1'b0};
        vecs[2]  = '{32'hFFFFFE80,   32'd0,          16'hFFFF,   1'b0};
        vecs[3]  = '{32'd127,        32'd0,          16'd0,      1'b0};
        vecs[4]  = '{32'h0FFFFFFF,   32'h0FFFFFFF,   16'h7FFF,   1'b1};
        vecs[5]  = '{32'h80000000,   32'h80000000,   16'h8000,   1'b1};
        vecs[6]  = '{32'd256,        32'd256,        16'd8,      1'b0};
        vecs[7]  = '{32'hFFFFFF7F,   32'd0,          16'hFFFF,   1'b0};
        vecs[8]  = '{32'd128,        32'd0,          16'd1,      1'b0};
        vecs[9]  = '{32'hFFFFFF80,   32'd0,          16'd0,      1'b0};
        vecs[10] = '{32'h007FFF00,   32'd0,          16'h7FFF,   1'b0};
        vecs[11] = '{32'h007FFF80,   32'd0,          16'h7FFF,   1'b1};
        vecs[12] = '{32'hFF800000,   32'd0,          16'h8000,   1'b0};
        vecs[13] = '{32'hFF7FFF7F,   32'd0,          16'h8000,   1'b1};

        rstP      = 1'b1;
        P_in      = '0;
        p_valid   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstP = 1'b0;

        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(p_ready), 32'd1);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_sat", 32'(out_sat), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_coef(vecs[i].first, vecs[i].rest, vecs[i].exp_data, vecs[i].exp_sat);
        end

        // Backpressure: upstream keeps offering a product while output is stalled.
        send_terms(32'd512, 32'd512);
        @(negedge clk);
        held_data = out_data;
        held_idx  = out_idx;
        chk("bp_data0", 32'(out_data), 32'd16);
        P_in    = 32'h00012345;
        p_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_ready", 32'(p_ready), 32'd0);
            chk("bp_data", 32'(out_data), 32'(held_data));
            chk("bp_idx", 32'(out_idx), 32'(held_idx));
        end
        p_valid = 1'b0;
        handshake();
        run_coef(32'd256, 32'd256, 16'd8, 1'b0);

        // Index wrap over 65 coefficients, data = coefficient number.
        do_reset();
        for (int i = 0; i < 65; i++) begin
            run_coef(32'(i * 256), 32'd0, 16'(i), 1'b0);
        end

        // Reset after three accepts discards the partial sum.
        do_reset();
        send(32'd5000);
        send(32'd5000);
        send(32'd5000);
        do_reset();
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_ready", 32'(p_ready), 32'd1);
        run_coef(32'd256, 32'd256, 16'd8, 1'b0);

        // Reset while holding drops the pending coefficient and its index.
        send_terms(32'd768, 32'd0);
        @(negedge clk);
        chk("pre_rst_hold", 32'(out_valid), 32'd1);
        do_reset();
        chk("rst_hold_valid", 32'(out_valid), 32'd0);
        chk("rst_hold_ready", 32'(p_ready), 32'd1);
        run_coef(32'd256, 32'd256, 16'd8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
